bcd_display_sequencer: RTL

//  Takes a binary value from the datapath and converts it to BCD by iterative

---
 rtl/bcd_display_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bcd_display_sequencer.sv
// Binary-to-BCD converter (double dabble, one bit per cycle) that then writes
// each BCD digit to its seven-segment decoder over a shared bus, one per cycle.
module bcd_display_sequencer #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [3:0]        digit_bcd,
  output logic [DIGITS-1:0] digit_we
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] WE_ONE = DIGITS'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             state_r, state_nx_s;
  logic [DATA_W-1:0]  shift_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [BCD_W-1:0]   bcd_adj_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic               busy_r, busy_nx_s;
  logic               done_r, done_nx_s;
  logic [3:0]         digit_bcd_r, digit_bcd_nx_s;
  logic [DIGITS-1:0]  digit_we_r, digit_we_nx_s;

  // Add 3 to every nibble that is 5 or more, so the following shift carries correctly.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd5) begin
        r[4*i +: 4] = nib + 4'd3;
      end else begin
        r[4*i +: 4] = nib;
      end
    end
    return r;
  endfunction

  // Mux-free digit select: OR of every nibble masked by its index match.
  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] v, input logic [IDX_W-1:0] idx);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (v[4*i +: 4] & {4{idx == IDX_W'(i)}});
    end
    return r;
  endfunction

  assign bcd_adj_s = add3_adjust(bcd_r);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and next values of the registered outputs.
  always_comb begin
    state_nx_s     = state_r;
    busy_nx_s      = 1'b1;
    done_nx_s      = 1'b0;
    digit_we_nx_s  = '0;
    digit_bcd_nx_s = digit_bcd_r;
    case (state_r)
      ST_IDLE: begin
        busy_nx_s = 1'b0;
        if (req) begin
          state_nx_s = ST_CONVERT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (cnt_r == CNT_W'(1)) begin
          state_nx_s = ST_WRITE;
        end else begin
          state_nx_s = ST_CONVERT;
        end
      end
      ST_WRITE: begin
        digit_bcd_nx_s = digit_at(bcd_r, idx_r);
        digit_we_nx_s  = WE_ONE << idx_r;
        if (idx_r == IDX_W'(DIGITS - 1)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        done_nx_s  = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        busy_nx_s  = 1'b0;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Conversion datapath: capture, shift-add-3 steps, digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= '0;
      bcd_r   <= '0;
      cnt_r   <= '0;
      idx_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            shift_r <= data_in;
            bcd_r   <= '0;
            cnt_r   <= CNT_W'(DATA_W);
            idx_r   <= '0;
          end
        end
        ST_CONVERT: begin
          bcd_r   <= {bcd_adj_s[BCD_W-2:0], shift_r[DATA_W-1]};
          shift_r <= {shift_r[DATA_W-2:0], 1'b0};
          cnt_r   <= cnt_r - CNT_W'(1);
        end
        ST_WRITE: begin
          idx_r <= idx_r + IDX_W'(1);
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      digit_bcd_r <= 4'd0;
      digit_we_r  <= '0;
    end else begin
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
      digit_bcd_r <= digit_bcd_nx_s;
      digit_we_r  <= digit_we_nx_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign digit_bcd = digit_bcd_r;
  assign digit_we  = digit_we_r;

endmodule
